issue_queue: RTL and testbench

Instruction buffer and dual-issue selector between instruction memory and the two ALU lanes/register read stage. Each fetch pushes two words. Each cycle it issues one or two in-order instructions to slots e/f. Slot f is enabled only when the pair has no control or data conflict. It back-pressures the PC register when near full and flushes on a taken jump.

---
 rtl/isa_pkg.sv | 37 +++
 rtl/issue_queue_if.sv | 25 ++
 rtl/issue_pair_check.sv | 29 ++
 rtl/issue_queue.sv | 124 ++++++++++++
 tb/tb_issue_queue.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode/funct constants and instruction decode helpers
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Register written by the instruction, 0 when it writes none.
    function automatic logic [4:0] dest_reg(input logic [31:0] ins);
        logic [4:0] d;
        case (ins[31:26])
            OP_RTYPE:       d = ins[15:11];
            OP_ADDI, OP_LW: d = ins[20:16];
            OP_JAL:         d = 5'd31;
            default:        d = 5'd0;
        endcase
        return d;
    endfunction

    // jr, jal and beq redirect the PC.
    function automatic logic is_control(input logic [31:0] ins);
        return ((ins[31:26] == OP_RTYPE) && (ins[5:0] == FN_JR)) ||
               (ins[31:26] == OP_JAL) || (ins[31:26] == OP_BEQ);
    endfunction

    // lw and sw share the single data-memory port.
    function automatic logic is_mem(input logic [31:0] ins);
        return (ins[31:26] == OP_LW) || (ins[31:26] == OP_SW);
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - fetch-side and issue-side signals of the issue queue
interface issue_queue_if #(parameter int PTR_W = 3);
    logic             in_valid;
    logic [31:0]      in_ins1;
    logic [31:0]      in_ins2;
    logic [31:0]      in_pc;
    logic             flush;
    logic             stall_pc;
    logic [31:0]      out_e;
    logic             out_e_valid;
    logic [31:0]      out_f;
    logic             out_f_valid;
    logic [31:0]      out_pc;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_ins1, in_ins2, in_pc, flush,
        input  stall_pc, out_e, out_e_valid, out_f, out_f_valid, out_pc, count
    );

    modport slave (
        input  in_valid, in_ins1, in_ins2, in_pc, flush,
        output stall_pc, out_e, out_e_valid, out_f, out_f_valid, out_pc, count
    );
endinterface

// File: rtl/issue_pair_check.sv
// rtl/issue_pair_check.sv - decides whether head and next may issue together
module issue_pair_check
    import isa_pkg::*;
(
    input  logic [31:0] head,
    input  logic [31:0] next,
    output logic        dual_ok
);

    logic [4:0] head_dst;
    logic [4:0] next_dst;
    logic       ctl_hit;
    logic       mem_hit;
    logic       raw_hit;
    logic       waw_hit;

    // Any control instruction, two memory ops, or a register dependency blocks pairing.
    always_comb begin
        head_dst = dest_reg(head);
        next_dst = dest_reg(next);
        ctl_hit  = is_control(head) || is_control(next);
        mem_hit  = is_mem(head) && is_mem(next);
        raw_hit  = (head_dst != 5'd0) &&
                   ((next[25:21] == head_dst) || (next[20:16] == head_dst));
        waw_hit  = (head_dst != 5'd0) && (next_dst == head_dst);
        dual_ok  = !(ctl_hit || mem_hit || raw_hit || waw_hit);
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - instruction buffer with in-order dual-issue selection
module issue_queue
    import isa_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    issue_queue_if.slave   bus
);

    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem_ins_q [DEPTH];
    logic [31:0]      mem_pc_q  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      out_e_q, out_e_d;
    logic             out_e_valid_q, out_e_valid_d;
    logic [31:0]      out_f_q, out_f_d;
    logic             out_f_valid_q, out_f_valid_d;
    logic [31:0]      out_pc_q, out_pc_d;

    logic             stall_pc;
    logic             push;
    logic             issue_e;
    logic             issue_f;
    logic             dual_ok;
    logic [PTR_W-1:0] next_ptr;
    logic [31:0]      head_ins;
    logic [31:0]      next_ins;

    assign next_ptr = rd_ptr_q + PTR_W'(1);
    assign head_ins = mem_ins_q[rd_ptr_q];
    assign next_ins = mem_ins_q[next_ptr];

    issue_pair_check u_pair_check (
        .head    (head_ins),
        .next    (next_ins),
        .dual_ok (dual_ok)
    );

    // Fewer than two free slots means the fetch pair cannot land; uses the pre-edge count.
    assign stall_pc = (count_q > CNT_W'(DEPTH - 2));
    assign push     = bus.in_valid && !stall_pc;
    assign issue_e  = (count_q != '0);
    assign issue_f  = (count_q >= CNT_W'(2)) && dual_ok;

    // Next-state for pointers, occupancy and the registered issue slots; flush overrides all but out_pc.
    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        out_e_d       = 32'd0;
        out_e_valid_d = 1'b0;
        out_f_d       = 32'd0;
        out_f_valid_d = 1'b0;
        out_pc_d      = out_pc_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue_e) begin
                out_e_d       = head_ins;
                out_e_valid_d = 1'b1;
                out_pc_d      = mem_pc_q[rd_ptr_q];
            end
            if (issue_f) begin
                out_f_d       = next_ins;
                out_f_valid_d = 1'b1;
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(issue_e) + PTR_W'(issue_f);
            wr_ptr_d = push ? (wr_ptr_q + PTR_W'(2)) : wr_ptr_q;
            count_d  = count_q + (push ? CNT_W'(2) : CNT_W'(0))
                     - CNT_W'(issue_e) - CNT_W'(issue_f);
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            out_e_q       <= 32'd0;
            out_e_valid_q <= 1'b0;
            out_f_q       <= 32'd0;
            out_f_valid_q <= 1'b0;
            out_pc_q      <= 32'd0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            out_e_q       <= out_e_d;
            out_e_valid_q <= out_e_valid_d;
            out_f_q       <= out_f_d;
            out_f_valid_q <= out_f_valid_d;
            out_pc_q      <= out_pc_d;
        end
    end

    // Entry storage needs no reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_ins_q[wr_ptr_q] <= bus.in_ins1;
            mem_pc_q[wr_ptr_q]  <= bus.in_pc;
            mem_ins_q[wr_ptr_q + PTR_W'(1)] <= bus.in_ins2;
            mem_pc_q[wr_ptr_q + PTR_W'(1)]  <= bus.in_pc + 32'd1;
        end
    end

    assign bus.stall_pc    = stall_pc;
    assign bus.out_e       = out_e_q;
    assign bus.out_e_valid = out_e_valid_q;
    assign bus.out_f       = out_f_q;
    assign bus.out_f_valid = out_f_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.count       = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed and randomized checks of issue_queue against a queue model
module tb_issue_queue;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    issue_queue_if #(.PTR_W(3)) bus ();

    issue_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        bit         ctl;
        bit         mem;
        logic [4:0] dst;
    } info_t;

    ent_t        mq[$];
    logic [31:0] exp_e, exp_f, exp_pc;
    logic        exp_ev, exp_fv;
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rs, input int rt, input int rd);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Decode straight from the instruction-set rules.
    function automatic info_t decode(input logic [31:0] ins);
        info_t r;
        r.ctl = 0; r.mem = 0; r.dst = 5'd0;
        case (ins[31:26])
            6'b000000: begin r.dst = ins[15:11]; r.ctl = (ins[5:0] == 6'b001000); end
            6'b000011: begin r.dst = 5'd31; r.ctl = 1; end
            6'b000100: r.ctl = 1;
            6'b001000: r.dst = ins[20:16];
            6'b100011: begin r.dst = ins[20:16]; r.mem = 1; end
            6'b101011: r.mem = 1;
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
        info_t ia = decode(a);
        info_t ib = decode(b);
        bit dep = (ia.dst != 0) &&
                  (b[25:21] == ia.dst || b[20:16] == ia.dst || ib.dst == ia.dst);
        return !(ia.ctl || ib.ctl) && !(ia.mem && ib.mem) && !dep;
    endfunction

    function automatic logic [31:0] rand_ins();
        int rs = $urandom_range(0, 7);
        int rt = $urandom_range(0, 7);
        int rd = $urandom_range(0, 7);
        case ($urandom_range(0, 8))
            0: return r_ins(6'b100000, rs, rt, rd);
            1: return r_ins(6'b100010, rs, rt, rd);
            2: return r_ins(6'b001000, rs, 0, 0);
            3: return {6'b000011, 26'($urandom_range(0, 255))};
            4: return i_ins(6'b000100, rs, rt, 4);
            5: return i_ins(6'b001000, rs, rt, 1);
            6: return i_ins(6'b100011, rs, rt, 0);
            7: return i_ins(6'b101011, rs, rt, 4);
            default: return {6'b111111, 26'($urandom)};
        endcase
    endfunction

    function automatic logic [3:0] model_cnt();
        return 4'(mq.size());
    endfunction

    function automatic bit model_stall();
        return (8 - mq.size()) < 2;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_e = 0; exp_f = 0; exp_ev = 0; exp_fv = 0; exp_pc = 0;
    endtask

    // One clock edge of the reference: issue from the old contents, then accept the pair.
    task automatic model_edge(input logic v, input logic [31:0] i1, input logic [31:0] i2,
                              input logic [31:0] pc, input logic fl);
        bit st = model_stall();
        exp_e = 0; exp_f = 0; exp_ev = 0; exp_fv = 0;
        if (fl) begin
            mq.delete();
            return;
        end
        if (mq.size() >= 1) begin
            exp_e = mq[0].ins; exp_pc = mq[0].pc; exp_ev = 1;
            if (mq.size() >= 2 && pair_ok(mq[0].ins, mq[1].ins)) begin
                exp_f = mq[1].ins; exp_fv = 1;
                void'(mq.pop_front());
            end
            void'(mq.pop_front());
        end
        if (v && !st) begin
            mq.push_back('{ins: i1, pc: pc});
            mq.push_back('{ins: i2, pc: pc + 1});
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".out_e"},  bus.out_e,       exp_e);
        chk({tag, ".e_vld"},  bus.out_e_valid, exp_ev);
        chk({tag, ".out_f"},  bus.out_f,       exp_f);
        chk({tag, ".f_vld"},  bus.out_f_valid, exp_fv);
        chk({tag, ".out_pc"}, bus.out_pc,      exp_pc);
        chk({tag, ".count"},  bus.count,       model_cnt());
    endtask

    task automatic cyc(input string tag, input logic v, input logic [31:0] i1,
                       input logic [31:0] i2, input logic [31:0] pc, input logic fl);
        @(negedge clk);
        bus.in_valid = v; bus.in_ins1 = i1; bus.in_ins2 = i2; bus.in_pc = pc; bus.flush = fl;
        #1;
        chk({tag, ".stall"}, bus.stall_pc, model_stall());
        model_edge(v, i1, i2, pc, fl);
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    logic [31:0] a1, a2, pcv;

    initial begin
        bus.in_valid = 0; bus.in_ins1 = 0; bus.in_ins2 = 0; bus.in_pc = 0; bus.flush = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset");
        chk("reset.stall", bus.stall_pc, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Independent adds pair up.
        cyc("dual", 1, r_ins(6'b100000, 1, 2, 3), r_ins(6'b100000, 4, 5, 6), 32'd0, 0);
        cyc("dual_iss", 0, 0, 0, 0, 0);
        chk("dual.f_const", bus.out_f, r_ins(6'b100000, 4, 5, 6));
        chk("dual.cnt0", bus.count, 4'd0);

        // RAW between add $3 and sub $7,$3,$4.
        cyc("raw", 1, r_ins(6'b100000, 1, 2, 3), r_ins(6'b100010, 3, 4, 7), 32'd0, 0);
        cyc("raw_c1", 0, 0, 0, 0, 0);
        chk("raw.f_vld_const", bus.out_f_valid, 1'b0);
        cyc("raw_c2", 0, 0, 0, 0, 0);
        chk("raw.pc_const", bus.out_pc, 32'd1);
        idle("raw_idle", 1);

        // beq issues alone, flush kills the trailing add.
        cyc("beq", 1, i_ins(6'b000100, 1, 2, 4), r_ins(6'b100000, 6, 7, 5), 32'd20, 0);
        cyc("beq_iss", 0, 0, 0, 0, 0);
        cyc("flush", 0, 0, 0, 0, 1);
        chk("flush.e_vld_const", bus.out_e_valid, 1'b0);
        idle("post_flush", 2);

        // Two loads per fetch: single issue, queue fills, stall throttles.
        for (int k = 0; k < 12; k++) begin
            pcv = 32'd100 + 32'(2 * k);
            if (!model_stall())
                cyc("lwlw", 1, i_ins(6'b100011, 1, 8, 0), i_ins(6'b100011, 1, 9, 4), pcv, 0);
            else
                cyc("lwlw_st", 1, i_ins(6'b100011, 1, 8, 0), i_ins(6'b100011, 1, 9, 4), pcv, 0);
        end

        // Asynchronous reset in the middle of a cycle.
        chk("prereset.nonempty", bus.count != 0, 1'b1);
        @(posedge clk);
        #3;
        bus.in_valid = 0; bus.flush = 0;
        rst = 1'b0;
        #1;
        model_reset();
        check_outs("areset");
        chk("areset.stall", bus.stall_pc, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Control, RAW and memory-pair conflicts each take two cycles.
        cyc("jal", 1, {6'b000011, 26'h10}, i_ins(6'b001000, 0, 31, 1), 32'd40, 0);
        cyc("jal_c1", 0, 0, 0, 0, 0);
        cyc("jal_c2", 0, 0, 0, 0, 0);
        cyc("lwadd", 1, i_ins(6'b100011, 0, 2, 0), r_ins(6'b100000, 2, 2, 4), 32'd50, 0);
        cyc("lwadd_c1", 0, 0, 0, 0, 0);
        cyc("lwadd_c2", 0, 0, 0, 0, 0);
        cyc("lwsw", 1, i_ins(6'b100011, 0, 2, 0), i_ins(6'b101011, 0, 3, 4), 32'd60, 0);
        cyc("lwsw_c1", 0, 0, 0, 0, 0);
        chk("lwsw.f_vld_const", bus.out_f_valid, 1'b0);
        cyc("lwsw_c2", 0, 0, 0, 0, 0);
        chk("lwsw.pc_const", bus.out_pc, 32'd61);

        // Randomized traffic with occasional flushes.
        pcv = 32'd200;
        for (int k = 0; k < 400; k++) begin
            a1 = rand_ins();
            a2 = rand_ins();
            cyc("rand", ($urandom_range(0, 3) != 0), a1, a2, pcv, ($urandom_range(0, 19) == 0));
            pcv = pcv + 32'd2;
        end
        idle("drain", 6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
